// File: rtl/sequential_counter_param.sv
// Parametrised up/down counter with parallel load, wrap/saturate modes, terminal-count pulse
// and sticky overflow on a 28-pin io bus. Define SEQ_COUNTER_PRESCALE_EN to add an enable prescaler.
module sequential_counter_param #(
    parameter int WIDTH    = 16,
    parameter int IO_WIDTH = 28,
    parameter int LOAD_LSB = 8
`ifdef SEQ_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE_LOG2 = 2
`endif
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [IO_WIDTH-1:0] io_in,
    output logic [IO_WIDTH-1:0] io_out,
    output logic [IO_WIDTH-1:0] io_oeb
);
    localparam int               LD_W    = IO_WIDTH - LOAD_LSB;
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic clr, en, dir, ld, sat;
    assign clr = io_in[0];
    assign en  = io_in[1];
    assign dir = io_in[2];
    assign ld  = io_in[3];
    assign sat = io_in[4];

    logic unused_pins;
    assign unused_pins = ^io_in[LOAD_LSB-1:5];

    logic [LD_W-1:0]  ld_field;
    logic [WIDTH-1:0] load_val;
    assign ld_field = io_in[IO_WIDTH-1:LOAD_LSB];

    // The load field is truncated or zero-extended to the counter width.
    generate
        if (LD_W >= WIDTH) begin : g_ld_trunc
            assign load_val = ld_field[WIDTH-1:0];
            if (LD_W > WIDTH) begin : g_ld_drop
                logic unused_ld_bits;
                assign unused_ld_bits = ^ld_field[LD_W-1:WIDTH];
            end
        end else begin : g_ld_ext
            assign load_val = {{(WIDTH-LD_W){1'b0}}, ld_field};
        end
    endgenerate

    logic step;

`ifdef SEQ_COUNTER_PRESCALE_EN
    logic [PRESCALE_LOG2-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q;
        if (clr || ld) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = pre_q + PRESCALE_LOG2'(1);
        end
    end

    // The counter only moves on the enabled cycle where the prescaler rolls over.
    assign step = en && (pre_q == {PRESCALE_LOG2{1'b1}});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign step = en;
`endif

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             at_bound;
    logic [WIDTH-1:0] stepped;

    always_comb begin
        cnt_d    = cnt_q;
        tc_d     = 1'b0;
        ovf_d    = ovf_q;
        at_bound = dir ? (cnt_q == '0) : (cnt_q == CNT_MAX);
        stepped  = dir ? (cnt_q - CNT_ONE) : (cnt_q + CNT_ONE);
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (ld) begin
            cnt_d = load_val;
        end else if (step) begin
            if (at_bound) begin
                // Stepping past the bound: wrap pulses tc, saturate holds silently.
                ovf_d = 1'b1;
                if (!sat) begin
                    cnt_d = stepped;
                    tc_d  = 1'b1;
                end
            end else begin
                cnt_d = stepped;
                tc_d  = sat && (stepped == (dir ? '0 : CNT_MAX));
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        io_out            = '0;
        io_out[WIDTH-1:0] = cnt_q;
        io_out[WIDTH]     = tc_q;
        io_out[WIDTH+1]   = ovf_q;
    end

    always_comb begin
        io_oeb            = '1;
        io_oeb[WIDTH+1:0] = '0;
    end

endmodule

// File: tb/tb_sequential_counter_param.sv
// Self-checking bench for sequential_counter_param: directed scenarios plus randomized
// control/load traffic compared against an arithmetic reference model.
module tb_sequential_counter_param;
    localparam int W       = 16;
    localparam int IOW     = 28;
    localparam int LSB     = 8;
    localparam int MAXV    = (1 << W) - 1;
    localparam int PS_LOG2 = 2;

    logic           clk;
    logic           resetn;
    logic [IOW-1:0] io_in;
    logic [IOW-1:0] io_out;
    logic [IOW-1:0] io_oeb;

    int n_vec = 0;
    int n_err = 0;

    int m_cnt;
    bit m_tc;
    bit m_ovf;
    int m_pre;

    sequential_counter_param #(
        .WIDTH   (W),
        .IO_WIDTH(IOW),
        .LOAD_LSB(LSB)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .io_in (io_in),
        .io_out(io_out),
        .io_oeb(io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [IOW-1:0] got, input logic [IOW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%07h expected 0x%07h", tag, got, exp);
        end
    endtask

    function automatic logic [IOW-1:0] oeb_exp();
        logic [IOW-1:0] e;
        e = '1;
        for (int i = 0; i <= W + 1; i++) e[i] = 1'b0;
        return e;
    endfunction

    function automatic logic [IOW-1:0] out_exp();
        logic [IOW-1:0] e;
        int             c;
        c = m_cnt;
        e = '0;
        for (int i = 0; i < W; i++) e[i] = c[i];
        e[W]     = m_tc;
        e[W + 1] = m_ovf;
        return e;
    endfunction

    function automatic void model_reset();
        m_cnt = 0;
        m_tc  = 0;
        m_ovf = 0;
        m_pre = 0;
    endfunction

    function automatic void model_step(input logic [IOW-1:0] v);
        int  ldv;
        int  t;
        bit  do_step;
        ldv = int'(v >> LSB) & MAXV;
        m_tc = 0;
        if (v[0]) begin
            m_cnt = 0;
            m_ovf = 0;
            m_pre = 0;
        end else if (v[3]) begin
            m_cnt = ldv;
            m_pre = 0;
        end else if (v[1]) begin
            do_step = 1;
`ifdef SEQ_COUNTER_PRESCALE_EN
            m_pre   = (m_pre + 1) % (1 << PS_LOG2);
            do_step = (m_pre == 0);
`endif
            if (do_step) begin
                t = m_cnt + (v[2] ? -1 : 1);
                if (t < 0 || t > MAXV) begin
                    m_ovf = 1;
                    if (!v[4]) begin
                        m_cnt = (t < 0) ? MAXV : 0;
                        m_tc  = 1;
                    end
                end else begin
                    m_cnt = t;
                    m_tc  = v[4] && (t == (v[2] ? 0 : MAXV));
                end
            end
        end
    endfunction

    task automatic apply(input logic [IOW-1:0] v, input string tag);
        io_in = v;
        @(posedge clk);
        model_step(v);
        @(negedge clk);
        chk(tag, io_out, out_exp());
        chk("oeb", io_oeb, oeb_exp());
    endtask

    function automatic logic [IOW-1:0] mk(input int ctl, input int val);
        logic [IOW-1:0] v;
        v = IOW'(ctl & 'h1f) | (IOW'(val) << LSB);
        return v;
    endfunction

    task automatic async_reset_pulse(input string tag);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk(tag, io_out, out_exp());
        @(negedge clk);
        chk({tag, "_hold"}, io_out, out_exp());
        resetn = 1'b1;
    endtask

    initial begin
        int r;
        int ctl;
        int val;
        resetn = 1'b0;
        io_in  = '0;
        model_reset();
        #12;
        chk("reset_out", io_out, '0);
        chk("reset_oeb", io_oeb, 28'hFFC0000);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) apply(mk('h3, 0), "clr_en");
        for (int i = 0; i < 6; i++) apply(mk('h2, 0), "count_up");

        apply(mk('h8, 'hFFFE), "load_fffe");
        for (int i = 0; i < 4; i++) apply(mk('h2, 0), "wrap_up");

        apply(mk('h8, 'h0002), "load_0002");
        for (int i = 0; i < 5; i++) apply(mk('h16, 0), "sat_down");
        for (int i = 0; i < 3; i++) apply(mk('h6, 0), "wrap_down");

        apply(mk('h9, 'h1234), "clr_ld");
        apply(mk('h8, 'h1234), "ld_1234");
        apply(mk('h0, 0), "hold");

        apply(mk('h8, 'hFFFD), "load_fffd");
        for (int i = 0; i < 4; i++) apply(mk('h12, 0), "sat_up");
        apply(mk('hA, 'h0007), "ld_over_en");

        apply(mk('h8, 'h004C), "load_004c");
        for (int i = 0; i < 4; i++) apply(mk('h2, 0), "to_0050");
        async_reset_pulse("async_rst");
        for (int i = 0; i < 3; i++) apply(mk('h2, 0), "after_rst");

        for (int i = 0; i < 600; i++) begin
            r   = $urandom_range(0, 99);
            ctl = $urandom_range(0, 255) & 'hE4;
            if ($urandom_range(0, 99) < 85) ctl |= 'h2;
            if ($urandom_range(0, 99) < 50) ctl |= 'h10;
            if (r < 3) ctl |= 'h1;
            else if (r < 12) ctl |= 'h8;
            case ($urandom_range(0, 5))
                0: val = 0;
                1: val = 1;
                2: val = MAXV - 1;
                3: val = MAXV;
                4: val = $urandom_range(0, MAXV);
                default: val = $urandom_range(0, (1 << (IOW - LSB)) - 1);
            endcase
            apply(mk(ctl, val) | IOW'(($urandom_range(0, 7)) << 5), "random");
            if ($urandom_range(0, 99) < 2) async_reset_pulse("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
